// File: rtl/scpu_io_pkg.sv
// Shared constants for the SCPU host I/O port.
//   DEF_DATA_W : default byte width on ext_in / ext_out
//   DEF_DEPTH  : default entries per FIFO (power of 2, >= 2)
//   CNT_W      : occupancy counter width for the default depth (0..DEPTH inclusive)
//   cnt_width  : occupancy counter width for an arbitrary depth
package scpu_io_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 4;
  localparam int CNT_W      = $clog2(DEF_DEPTH) + 1;

  // One extra bit so a completely full FIFO (count == depth) is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/scpu_io_fifo.sv
// Synchronous show-ahead FIFO with last-value hold.
//   clk, rst     : clock, synchronous active-high reset (empties FIFO, clears held byte)
//   i_push       : write strobe; ignored when full
//   i_push_data  : byte written on push
//   i_pop        : read strobe; ignored when empty
//   o_data       : head entry when not empty, otherwise the last popped byte
//   o_count      : occupancy 0..DEPTH
//   o_full       : count == DEPTH
//   o_empty      : count == 0
module scpu_io_fifo
  import scpu_io_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic [DATA_W-1:0]            i_push_data,
  input  logic                         i_pop,
  output logic [DATA_W-1:0]            o_data,
  output logic [cnt_width(DEPTH)-1:0]  o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = cnt_width(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] r_last;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  // Full/empty come from the registered count, so a pop never frees room
  // for a push in the same cycle.
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap by natural overflow.
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_last   <= r_mem[r_rd_ptr];
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: it is only observed while the count says it is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_data  = o_empty ? r_last : r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/scpu_io_port.sv
// Host-side I/O adapter for the SCPU external byte port.
//   host_in_*  : valid/ready stream from host, buffered toward the CPU ext_in
//   ext_in*    : show-ahead head of the in-FIFO; ext_in_rd pops it
//   ext_out*   : CPU write strobe pushes into the out-FIFO
//   host_out_* : valid/ready stream toward host from the out-FIFO head
//   in_count / out_count : FIFO occupancies
//   underflow  : sticky, CPU read while in-FIFO empty
//   overflow   : sticky, CPU write while out-FIFO full (byte dropped)
// Flags and buffered data are cleared only by the synchronous reset.
module scpu_io_port
  import scpu_io_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_W-1:0]            host_in_data,
  input  logic                         host_in_valid,
  output logic                         host_in_ready,
  output logic [DATA_W-1:0]            host_out_data,
  output logic                         host_out_valid,
  input  logic                         host_out_ready,
  output logic [DATA_W-1:0]            ext_in,
  output logic                         ext_in_valid,
  input  logic                         ext_in_rd,
  input  logic [DATA_W-1:0]            ext_out,
  input  logic                         ext_out_wr,
  output logic [cnt_width(DEPTH)-1:0]  in_count,
  output logic [cnt_width(DEPTH)-1:0]  out_count,
  output logic                         underflow,
  output logic                         overflow
);

  logic w_in_push;
  logic w_in_full;
  logic w_in_empty;
  logic w_out_pop;
  logic w_out_full;
  logic w_out_empty;
  logic r_underflow;
  logic r_overflow;

  // Ready is held low while rst is asserted and otherwise follows the
  // registered occupancy only.
  assign host_in_ready = ~rst & ~w_in_full;
  assign w_in_push     = host_in_valid & host_in_ready;
  assign ext_in_valid  = ~w_in_empty;

  assign host_out_valid = ~w_out_empty;
  assign w_out_pop      = host_out_valid & host_out_ready;

  scpu_io_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_in_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_in_push),
    .i_push_data (host_in_data),
    .i_pop       (ext_in_rd),
    .o_data      (ext_in),
    .o_count     (in_count),
    .o_full      (w_in_full),
    .o_empty     (w_in_empty)
  );

  // The CPU cannot be back-pressured: a write into a full FIFO is dropped
  // inside the FIFO and recorded by the overflow flag below.
  scpu_io_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_out_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (ext_out_wr),
    .i_push_data (ext_out),
    .i_pop       (w_out_pop),
    .o_data      (host_out_data),
    .o_count     (out_count),
    .o_full      (w_out_full),
    .o_empty     (w_out_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (ext_in_rd & w_in_empty)  r_underflow <= 1'b1;
      if (ext_out_wr & w_out_full) r_overflow  <= 1'b1;
    end
  end

  assign underflow = r_underflow;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_scpu_io_port.sv
module tb_scpu_io_port;
  import scpu_io_pkg::*;

  logic              clk;
  logic              rst;
  logic [7:0]        host_in_data;
  logic              host_in_valid;
  logic              host_in_ready;
  logic [7:0]        host_out_data;
  logic              host_out_valid;
  logic              host_out_ready;
  logic [7:0]        ext_in;
  logic              ext_in_valid;
  logic              ext_in_rd;
  logic [7:0]        ext_out;
  logic              ext_out_wr;
  logic [CNT_W-1:0]  in_count;
  logic [CNT_W-1:0]  out_count;
  logic              underflow;
  logic              overflow;

  int n_chk  = 0;
  int n_fail = 0;

  scpu_io_port #(.DATA_W(DEF_DATA_W), .DEPTH(DEF_DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .host_in_data   (host_in_data),
    .host_in_valid  (host_in_valid),
    .host_in_ready  (host_in_ready),
    .host_out_data  (host_out_data),
    .host_out_valid (host_out_valid),
    .host_out_ready (host_out_ready),
    .ext_in         (ext_in),
    .ext_in_valid   (ext_in_valid),
    .ext_in_rd      (ext_in_rd),
    .ext_out        (ext_out),
    .ext_out_wr     (ext_out_wr),
    .in_count       (in_count),
    .out_count      (out_count),
    .underflow      (underflow),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       hiv;
    logic [7:0] hid;
    logic       rd;
    logic       wr;
    logic [7:0] eo;
    logic       hor;
    logic [7:0] ein;
    logic       eiv;
    logic [2:0] ic;
    logic       hir;
    logic [7:0] hod;
    logic       hov;
    logic [2:0] oc;
    logic       uf;
    logic       of;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic r, input logic hiv, input logic [7:0] hid, input logic rd,
    input logic wr, input logic [7:0] eo, input logic hor,
    input logic [7:0] ein, input logic eiv, input logic [2:0] ic, input logic hir,
    input logic [7:0] hod, input logic hov, input logic [2:0] oc,
    input logic uf, input logic of);
    vec_t v;
    v.rst = r;   v.hiv = hiv; v.hid = hid; v.rd = rd;
    v.wr = wr;   v.eo = eo;   v.hor = hor;
    v.ein = ein; v.eiv = eiv; v.ic = ic;   v.hir = hir;
    v.hod = hod; v.hov = hov; v.oc = oc;   v.uf = uf; v.of = of;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic hiv, input logic [7:0] hid,
                       input logic rd, input logic wr, input logic [7:0] eo, input logic hor);
    rst = r; host_in_valid = hiv; host_in_data = hid; ext_in_rd = rd;
    ext_out_wr = wr; ext_out = eo; host_out_ready = hor;
  endtask

  initial begin
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);

    // Reset held two cycles, then idle.
    tbl.push_back(mk(1,0,8'h00,0,0,8'h00,0, 8'h00,0,0,0, 8'h00,0,0, 0,0));
    tbl.push_back(mk(1,0,8'h00,0,0,8'h00,0, 8'h00,0,0,0, 8'h00,0,0, 0,0));
    tbl.push_back(mk(0,0,8'h00,0,0,8'h00,0, 8'h00,0,0,1, 8'h00,0,0, 0,0));
    // Two host bytes, then CPU reads them.
    tbl.push_back(mk(0,1,8'h0F,0,0,8'h00,0, 8'h0F,1,1,1, 8'h00,0,0, 0,0));
    tbl.push_back(mk(0,1,8'h10,0,0,8'h00,0, 8'h0F,1,2,1, 8'h00,0,0, 0,0));
    tbl.push_back(mk(0,0,8'h00,1,0,8'h00,0, 8'h10,1,1,1, 8'h00,0,0, 0,0));
    tbl.push_back(mk(0,0,8'h00,1,0,8'h00,0, 8'h10,0,0,1, 8'h00,0,0, 0,0));
    // Read on empty: underflow, ext_in holds last byte.
    tbl.push_back(mk(0,0,8'h00,1,0,8'h00,0, 8'h10,0,0,1, 8'h00,0,0, 1,0));
    // Fill in-FIFO; fifth byte refused.
    tbl.push_back(mk(0,1,8'h21,0,0,8'h00,0, 8'h21,1,1,1, 8'h00,0,0, 1,0));
    tbl.push_back(mk(0,1,8'h22,0,0,8'h00,0, 8'h21,1,2,1, 8'h00,0,0, 1,0));
    tbl.push_back(mk(0,1,8'h23,0,0,8'h00,0, 8'h21,1,3,1, 8'h00,0,0, 1,0));
    tbl.push_back(mk(0,1,8'h24,0,0,8'h00,0, 8'h21,1,4,0, 8'h00,0,0, 1,0));
    tbl.push_back(mk(0,1,8'h25,0,0,8'h00,0, 8'h21,1,4,0, 8'h00,0,0, 1,0));
    // Full + pop + host valid: no same-cycle credit, 26 refused.
    tbl.push_back(mk(0,1,8'h26,1,0,8'h00,0, 8'h22,1,3,1, 8'h00,0,0, 1,0));
    // Simultaneous push+pop on partially full FIFO: count unchanged.
    tbl.push_back(mk(0,1,8'h27,1,0,8'h00,0, 8'h23,1,3,1, 8'h00,0,0, 1,0));
    tbl.push_back(mk(0,0,8'h00,1,0,8'h00,0, 8'h24,1,2,1, 8'h00,0,0, 1,0));
    tbl.push_back(mk(0,0,8'h00,1,0,8'h00,0, 8'h27,1,1,1, 8'h00,0,0, 1,0));
    tbl.push_back(mk(0,0,8'h00,1,0,8'h00,0, 8'h27,0,0,1, 8'h00,0,0, 1,0));
    // CPU writes A5..A9 with host stalled: A9 dropped, overflow.
    tbl.push_back(mk(0,0,8'h00,0,1,8'hA5,0, 8'h27,0,0,1, 8'hA5,1,1, 1,0));
    tbl.push_back(mk(0,0,8'h00,0,1,8'hA6,0, 8'h27,0,0,1, 8'hA5,1,2, 1,0));
    tbl.push_back(mk(0,0,8'h00,0,1,8'hA7,0, 8'h27,0,0,1, 8'hA5,1,3, 1,0));
    tbl.push_back(mk(0,0,8'h00,0,1,8'hA8,0, 8'h27,0,0,1, 8'hA5,1,4, 1,0));
    tbl.push_back(mk(0,0,8'h00,0,1,8'hA9,0, 8'h27,0,0,1, 8'hA5,1,4, 1,1));
    // Host drains in order; extra ready on empty is ignored.
    tbl.push_back(mk(0,0,8'h00,0,0,8'h00,1, 8'h27,0,0,1, 8'hA6,1,3, 1,1));
    tbl.push_back(mk(0,0,8'h00,0,0,8'h00,1, 8'h27,0,0,1, 8'hA7,1,2, 1,1));
    tbl.push_back(mk(0,0,8'h00,0,0,8'h00,1, 8'h27,0,0,1, 8'hA8,1,1, 1,1));
    tbl.push_back(mk(0,0,8'h00,0,0,8'h00,1, 8'h27,0,0,1, 8'hA8,0,0, 1,1));
    tbl.push_back(mk(0,0,8'h00,0,0,8'h00,1, 8'h27,0,0,1, 8'hA8,0,0, 1,1));
    // Simultaneous CPU write and host pop at out_count=2.
    tbl.push_back(mk(0,0,8'h00,0,1,8'hB1,0, 8'h27,0,0,1, 8'hB1,1,1, 1,1));
    tbl.push_back(mk(0,0,8'h00,0,1,8'hB2,0, 8'h27,0,0,1, 8'hB1,1,2, 1,1));
    tbl.push_back(mk(0,0,8'h00,0,1,8'hB3,1, 8'h27,0,0,1, 8'hB2,1,2, 1,1));
    tbl.push_back(mk(0,0,8'h00,0,1,8'hB4,1, 8'h27,0,0,1, 8'hB3,1,2, 1,1));
    tbl.push_back(mk(0,0,8'h00,0,0,8'h00,1, 8'h27,0,0,1, 8'hB4,1,1, 1,1));
    tbl.push_back(mk(0,1,8'h31,0,1,8'hB5,0, 8'h31,1,1,1, 8'hB4,1,2, 1,1));
    // Reset mid-stream discards everything and clears flags.
    tbl.push_back(mk(1,1,8'h32,1,1,8'hB6,1, 8'h00,0,0,0, 8'h00,0,0, 0,0));
    tbl.push_back(mk(0,0,8'h00,0,0,8'h00,0, 8'h00,0,0,1, 8'h00,0,0, 0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].hiv, tbl[i].hid, tbl[i].rd, tbl[i].wr, tbl[i].eo, tbl[i].hor);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.ext_in", i),         32'(ext_in),         32'(tbl[i].ein));
      chk($sformatf("v%0d.ext_in_valid", i),   32'(ext_in_valid),   32'(tbl[i].eiv));
      chk($sformatf("v%0d.in_count", i),       32'(in_count),       32'(tbl[i].ic));
      chk($sformatf("v%0d.host_in_ready", i),  32'(host_in_ready),  32'(tbl[i].hir));
      chk($sformatf("v%0d.host_out_data", i),  32'(host_out_data),  32'(tbl[i].hod));
      chk($sformatf("v%0d.host_out_valid", i), 32'(host_out_valid), 32'(tbl[i].hov));
      chk($sformatf("v%0d.out_count", i),      32'(out_count),      32'(tbl[i].oc));
      chk($sformatf("v%0d.underflow", i),      32'(underflow),      32'(tbl[i].uf));
      chk($sformatf("v%0d.overflow", i),       32'(overflow),       32'(tbl[i].of));
    end

    // Streaming through both FIFOs at occupancy 1 for 10 bytes: pointers
    // wrap several times and order must hold.
    for (int k = 0; k < 10; k++) begin
      logic [7:0] b_in;
      logic [7:0] b_out;
      b_in  = 8'h40 + 8'(k);
      b_out = 8'h60 + 8'(k);
      @(negedge clk);
      drive(1'b0, 1'b1, b_in, (k != 0), 1'b1, b_out, (k != 0));
      @(posedge clk);
      #1;
      chk($sformatf("wrap%0d.ext_in", k),        32'(ext_in),        32'(b_in));
      chk($sformatf("wrap%0d.in_count", k),      32'(in_count),      32'd1);
      chk($sformatf("wrap%0d.host_out_data", k), 32'(host_out_data), 32'(b_out));
      chk($sformatf("wrap%0d.out_count", k),     32'(out_count),     32'd1);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
    @(posedge clk);
    #1;
    chk("wrap_end.ext_in",        32'(ext_in),         32'h49);
    chk("wrap_end.ext_in_valid",  32'(ext_in_valid),   32'd0);
    chk("wrap_end.host_out_data", 32'(host_out_data),  32'h69);
    chk("wrap_end.host_out_valid",32'(host_out_valid), 32'd0);
    chk("wrap_end.flags",         32'({underflow, overflow}), 32'd0);

    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
